// File: rtl/mac_relu_neuron_pkg.sv
// Shared Q8.8 constants, FSM state encoding and the saturation helper for the neuron.
package relu_nn_pkg;

    localparam logic [15:0] Q_ONE = 16'h0100;
    localparam logic [15:0] Q_MAX = 16'h7FFF;
    localparam logic [15:0] Q_MIN = 16'h8000;

    localparam int SAT_W = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        DRAIN  = 3'd2,
        FINISH = 3'd3,
        OUT    = 3'd4
    } state_t;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    clip;
    } sat_t;

    // Clamp a wide signed value into a signed range of the given width.
    function automatic sat_t sat_q(input logic signed [SAT_W-1:0] acc, input int unsigned width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t r;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        r.clip = 1'b1;
        if (acc > hi) begin
            r.val = hi;
        end else if (acc < lo) begin
            r.val = lo;
        end else begin
            r.val  = acc;
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_relu_neuron_if.sv
// Input beat stream and output result stream of the neuron, both valid/ready.
interface mac_relu_neuron_if #(parameter int WIDTH = 16);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic signed [WIDTH-1:0] in_weight;
    logic signed [WIDTH-1:0] bias;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_sat;

    modport master (
        output in_valid, in_data, in_weight, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_weight, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/mac_relu_neuron_act.sv
// Combinational bias add, Q-format shift, saturation and activation ahead of the output register.
// Build option: RELU_NN_LEAKY_EN selects leaky ReLU instead of plain ReLU.
module neuron_act
    import relu_nn_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int ACC_W      = 34,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [WIDTH-1:0] bias,
    output logic signed [WIDTH-1:0] result,
    output logic                    sat
);

    localparam int SUM_W = ACC_W + 1;

    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= WIDTH) begin : g_bad_leak
        $error("LEAK_SHIFT must lie in [0, WIDTH-1]");
    end

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] pre;
    logic signed [WIDTH-1:0] clipped;
    sat_t                    s;
    logic                    unused_hi;

    always_comb begin
        sum       = SUM_W'(acc) + (SUM_W'(bias) <<< FRAC);
        pre       = sum >>> FRAC;
        s         = sat_q(64'(pre), WIDTH);
        clipped   = s.val[WIDTH-1:0];
        unused_hi = ^s.val[SAT_W-1:WIDTH];
        sat       = s.clip;
        result    = clipped;
        if (clipped[WIDTH-1]) begin
`ifdef RELU_NN_LEAKY_EN
            result = clipped >>> LEAK_SHIFT;
`else
            result = '0;
`endif
        end
    end

endmodule

// File: rtl/mac_relu_neuron.sv
// Serial-beat fixed-point neuron: full-precision MAC over N_IN beats, bias, saturate, ReLU.
// Build option: RELU_NN_LEAKY_EN (leaky activation, handled inside neuron_act).
//
// state  | meaning
// IDLE   | waiting for the first beat of a vector, accumulator cleared
// ACCUM  | taking the remaining beats of the vector
// DRAIN  | last product being added into the accumulator
// FINISH | bias/shift/saturate/activate, result registered
// OUT    | result presented until downstream takes it
module mac_relu_neuron
    import relu_nn_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int N_IN       = 2,
    parameter int LEAK_SHIFT = 3
) (
    input logic              clk,
    input logic              rst,
    mac_relu_neuron_if.slave bus
);

    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam int ACC_W  = 2 * WIDTH + CNT_W;
    localparam int PROD_W = 2 * WIDTH;

    state_t state;
    state_t state_nxt;

    logic                    in_rdy;
    logic                    out_vld;
    logic                    beat;
    logic                    last_beat;
    logic                    out_fire;
    logic [CNT_W-1:0]        beat_cnt;
    logic signed [PROD_W-1:0] prod;
    logic                    prod_vld;
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDTH-1:0] bias_reg;
    logic signed [WIDTH-1:0] act_data;
    logic                    act_sat;
    logic signed [WIDTH-1:0] out_data_r;
    logic                    out_sat_r;

    assign beat      = bus.in_valid && in_rdy;
    assign last_beat = beat && (beat_cnt == CNT_W'(N_IN - 1));
    assign out_fire  = out_vld && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (beat) state_nxt = last_beat ? DRAIN : ACCUM;
            DRAIN:       state_nxt = FINISH;
            FINISH:      state_nxt = OUT;
            OUT:         if (bus.out_ready) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state)
            IDLE, ACCUM: in_rdy  = 1'b1;
            OUT:         out_vld = 1'b1;
            default:     ;
        endcase
    end

    // Products land one cycle after their beat; the accumulator is cleared as the result leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            prod       <= '0;
            prod_vld   <= 1'b0;
            acc        <= '0;
            bias_reg   <= '0;
            out_data_r <= '0;
            out_sat_r  <= 1'b0;
        end else begin
            prod_vld <= beat;
            if (beat) begin
                prod     <= PROD_W'(bus.in_data) * PROD_W'(bus.in_weight);
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            if (beat && state == IDLE) bias_reg <= bus.bias;
            if (out_fire)      acc <= '0;
            else if (prod_vld) acc <= acc + ACC_W'(prod);
            if (state == FINISH) begin
                out_data_r <= act_data;
                out_sat_r  <= act_sat;
            end
        end
    end

    neuron_act #(
        .WIDTH      (WIDTH),
        .FRAC       (FRAC),
        .ACC_W      (ACC_W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_act (
        .acc    (acc),
        .bias   (bias_reg),
        .result (act_data),
        .sat    (act_sat)
    );

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;

endmodule

// File: tb/tb_mac_relu_neuron.sv
// Directed bench for mac_relu_neuron with an arithmetic reference model checked every cycle.
module tb_mac_relu_neuron;
    import relu_nn_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_relu_neuron_if #(.WIDTH(16)) bus ();

    mac_relu_neuron #(.WIDTH(16), .FRAC(8), .N_IN(N), .LEAK_SHIFT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          ready_at;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];
    logic signed [15:0] pa[$];
    logic signed [15:0] pw[$];
    logic signed [15:0] pb;

    int          cyc          = 0;
    logic        prev_rst     = 1'b0;
    logic        prev_ovalid  = 1'b0;
    int          hs_count     = 0;
    logic [15:0] last_data    = '0;
    logic        last_sat     = 1'b0;
    int          last_beat_n  = 0;
    int          valid_rise_n = 0;
    int          stall_cnt    = 0;
    int          beats_seen   = 0;
    int          beats_sent   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    // Reference: real-valued dot product in Q16.16, floored back to Q8.8, clipped, activated.
    function automatic exp_t model(input logic signed [15:0] a[$], input logic signed [15:0] w[$],
                                   input logic signed [15:0] b);
        exp_t   r;
        longint sum = 0;
        longint pre;
        foreach (a[i]) sum += longint'(a[i]) * longint'(w[i]);
        sum += longint'(b) * 256;
        pre = floor_div(sum, 256);
        r.s = 1'b0;
        if (pre > 32767)  begin pre = 32767;  r.s = 1'b1; end
        if (pre < -32768) begin pre = -32768; r.s = 1'b1; end
        if (pre < 0) begin
`ifdef RELU_NN_LEAKY_EN
            pre = floor_div(pre, 8);
`else
            pre = 0;
`endif
        end
        r.d = pre[15:0];
        r.ready_at = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic exp_v;
        cyc++;
        if (prev_rst && !rst) begin
            chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
            chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
            chk("reset_out_data",  32'(bus.out_data),  32'd0);
            chk("reset_out_sat",   32'(bus.out_sat),   32'd0);
        end
        if (rst) begin
            exp_q.delete();
            pa.delete();
            pw.delete();
        end else begin
            exp_v = (exp_q.size() > 0) && (cyc >= exp_q[0].ready_at);
            chk("in_ready",  32'(bus.in_ready),  32'(exp_q.size() == 0));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
            if (bus.out_valid && !prev_ovalid) valid_rise_n = cyc;
            if (bus.out_valid && exp_q.size() > 0) begin
                chk("out_data", 32'(bus.out_data), 32'(exp_q[0].d));
                chk("out_sat",  32'(bus.out_sat),  32'(exp_q[0].s));
                if (!bus.out_ready) stall_cnt++;
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    last_data = bus.out_data;
                    last_sat  = bus.out_sat;
                    hs_count++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                beats_seen++;
                if (pa.size() == 0) pb = bus.bias;
                pa.push_back(bus.in_data);
                pw.push_back(bus.in_weight);
                if (pa.size() == N) begin
                    e = model(pa, pw, pb);
                    e.ready_at = cyc + 3;
                    exp_q.push_back(e);
                    last_beat_n = cyc;
                    pa.delete();
                    pw.delete();
                end
            end
        end
        prev_rst    = rst;
        prev_ovalid = bus.out_valid;
    end

    // All driver tasks start and end #1 after a rising edge.
    task automatic send_beat(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
        int guard = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = a;
        bus.in_weight = w;
        bus.bias      = b;
        @(negedge clk);
        while (!bus.in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) chk("beat_accept_timeout", 32'd0, 32'd1);
        else beats_sent++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [15:0] a0, input logic [15:0] w0,
                            input logic [15:0] a1, input logic [15:0] w1,
                            input logic [15:0] b, input int gap);
        send_beat(a0, w0, b);
        repeat (gap) @(posedge clk);
        #1;
        send_beat(a1, w1, 16'h0000);
    endtask

    task automatic wait_result(input int target);
        int guard = 0;
        while (hs_count < target && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (hs_count < target) chk("result_timeout", 32'(hs_count), 32'(target));
    endtask

    int s0;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        bus.bias      = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: 1*1 + 1*1 - 1 = 1.0
        send_vec(Q_ONE, Q_ONE, Q_ONE, Q_ONE, 16'hFF00, 0);
        wait_result(1);
        chk("t1_data", 32'(last_data), 32'h0100);
        chk("t1_sat", 32'(last_sat), 32'd0);
        chk("t1_latency", 32'(valid_rise_n - last_beat_n), 32'd3);

        // 2: 1*(-2) + 0 = -2.0
        send_vec(16'h0100, 16'hFE00, 16'h0000, 16'h0100, 16'h0000, 0);
        wait_result(2);
`ifdef RELU_NN_LEAKY_EN
        chk("t2_data", 32'(last_data), 32'hFFC0);
`else
        chk("t2_data", 32'(last_data), 32'h0000);
`endif
        chk("t2_sat", 32'(last_sat), 32'd0);

        // 3: 127*127 clips high
        send_vec(16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 0);
        wait_result(3);
        chk("t3_data", 32'(last_data), {16'h0, Q_MAX});
        chk("t3_sat", 32'(last_sat), 32'd1);

        // 4: back-pressure for 5 cycles with junk beats offered
        bus.out_ready = 1'b0;
        s0 = stall_cnt;
        send_vec(16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 0);
        for (int g = 0; g < 20 && !bus.out_valid; g++) @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        bus.in_weight = 16'h4321;
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_result(4);
        chk("t4_stall_cycles", 32'(stall_cnt - s0), 32'd5);
        chk("t4_data", 32'(last_data), 32'h7FFF);
        chk("t4_in_ready_after", 32'(bus.in_ready), 32'd1);

        // 5: reset between the two beats discards the partial vector
        send_beat(Q_ONE, Q_ONE, 16'hFF00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_vec(Q_ONE, Q_ONE, Q_ONE, Q_ONE, 16'hFF00, 0);
        wait_result(5);
        chk("t5_data", 32'(last_data), 32'h0100);

        // 6: gapped beats, then four vectors back to back
        send_vec(Q_ONE, Q_ONE, Q_ONE, Q_ONE, 16'hFF00, 3);
        wait_result(6);
        chk("t6_gap_data", 32'(last_data), 32'h0100);
        send_vec(Q_ONE, Q_ONE, Q_ONE, Q_ONE, 16'hFF00, 0);
        send_vec(16'h0100, 16'hFE00, 16'h0000, 16'h0100, 16'h0000, 0);
        send_vec(16'h7F00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 0);
        send_vec(16'h0080, 16'h0200, 16'hFF00, 16'h0100, 16'h0040, 0);
        wait_result(10);
        chk("t6_last_data", 32'(last_data), 32'h0040);
        chk("t6_last_sat", 32'(last_sat), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("results_total", 32'(hs_count), 32'd10);
        chk("beats_total", 32'(beats_seen), 32'(beats_sent));
        chk("pending_left", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
